fp_agg_scheduler: RTL and testbench

Issue controller for the four-input floating-point adder tree. It waits until all four worker lanes present an element, then issues them to the tree in lock-step for a programmed vector length. Issue is gated by a credit counter so the downstream result FIFO can never overflow, whatever the tree latency. It sits between the four AXI-stream worker inputs and the adder tree / result FIFO pair.

---
 rtl/fp_agg_pkg.sv | 18 +
 rtl/fp_agg_credit_counter.sv | 35 +++
 rtl/fp_agg_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_fp_agg_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_agg_pkg.sv
// fp_agg_pkg: shared types and helpers for the four-lane FP adder-tree issue controller.
package fp_agg_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Width needed to hold every value from 0 up to and including depth
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fp_agg_credit_counter.sv
// fp_agg_credit_counter: counts result-FIFO slots claimed by issued-but-unread results.
module fp_agg_credit_counter
    import fp_agg_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int CW         = credit_width(FIFO_DEPTH)
) (
    input  logic clk,
    input  logic srst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_credit_ok
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [CW-1:0] r_credits_used;
    logic          w_dec_ok;

    // A read with nothing accounted for is consumer misuse and is dropped
    assign w_dec_ok = i_dec && (r_credits_used != '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_credits_used <= '0;
        end else if (i_inc && !i_dec) begin
            r_credits_used <= r_credits_used + CW'(1);
        end else if (!i_inc && w_dec_ok) begin
            r_credits_used <= r_credits_used - CW'(1);
        end
    end

    assign o_credit_ok = (r_credits_used < DEPTH_C);

endmodule

// File: rtl/fp_agg_scheduler.sv
// fp_agg_scheduler: lock-step, credit-gated issue of four worker lanes into the FP adder tree.
// Define FP_AGG_TIMEOUT_EN to build the partial-arrival watchdog.
module fp_agg_scheduler
    import fp_agg_pkg::*;
#(
    parameter int FP_DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int VEC_LEN_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     start,
    input  logic [VEC_LEN_WIDTH-1:0] vec_len,
    output logic                     busy,
    output logic                     done,
    output logic                     tlast_err,
    output logic                     timeout_err,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_0_tdata,
    input  logic                     S_AXIS_0_tvalid,
    input  logic                     S_AXIS_0_tlast,
    output logic                     S_AXIS_0_tready,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_1_tdata,
    input  logic                     S_AXIS_1_tvalid,
    input  logic                     S_AXIS_1_tlast,
    output logic                     S_AXIS_1_tready,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_2_tdata,
    input  logic                     S_AXIS_2_tvalid,
    input  logic                     S_AXIS_2_tlast,
    output logic                     S_AXIS_2_tready,
    input  logic [FP_DATA_WIDTH-1:0] S_AXIS_3_tdata,
    input  logic                     S_AXIS_3_tvalid,
    input  logic                     S_AXIS_3_tlast,
    output logic                     S_AXIS_3_tready,
    output logic [FP_DATA_WIDTH-1:0] issue_tdata_0,
    output logic [FP_DATA_WIDTH-1:0] issue_tdata_1,
    output logic [FP_DATA_WIDTH-1:0] issue_tdata_2,
    output logic [FP_DATA_WIDTH-1:0] issue_tdata_3,
    output logic                     issue_tvalid,
    input  logic                     tree_result_valid,
    input  logic                     result_rd_en,
    input  logic                     result_empty
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                   r_state, w_state_next;
    logic [VEC_LEN_WIDTH-1:0] r_len, r_issued_cnt, r_result_cnt, w_result_cnt_next;
    logic [FP_DATA_WIDTH-1:0] w_tdata      [NUM_LANES];
    logic [FP_DATA_WIDTH-1:0] r_issue_data [NUM_LANES];
    logic [NUM_LANES-1:0]     w_tvalid, w_tlast;
    logic                     w_credit_ok, w_fire, w_last_elem, w_tlast_bad, w_counting;
    logic                     w_wd_expire, w_done_set, w_tlast_err_set, w_start_vec;
    logic                     r_issue_valid, r_done, r_tlast_err;

    assign w_tdata[0] = S_AXIS_0_tdata;
    assign w_tdata[1] = S_AXIS_1_tdata;
    assign w_tdata[2] = S_AXIS_2_tdata;
    assign w_tdata[3] = S_AXIS_3_tdata;
    assign w_tvalid   = {S_AXIS_3_tvalid, S_AXIS_2_tvalid, S_AXIS_1_tvalid, S_AXIS_0_tvalid};
    assign w_tlast    = {S_AXIS_3_tlast, S_AXIS_2_tlast, S_AXIS_1_tlast, S_AXIS_0_tlast};

    // Lanes are only ever accepted together, and only while a FIFO slot is guaranteed
    assign w_fire      = (r_state == RUN) && (&w_tvalid) && w_credit_ok;
    assign w_last_elem = (r_issued_cnt == (r_len - VEC_LEN_WIDTH'(1)));
    assign w_tlast_bad = w_last_elem ? !(&w_tlast) : (|w_tlast);
    assign w_counting  = (r_state == RUN) || (r_state == DRAIN);
    assign w_start_vec = (r_state == IDLE) && start && (vec_len != '0);
    assign w_result_cnt_next = r_result_cnt + VEC_LEN_WIDTH'(w_counting && tree_result_valid);

    assign S_AXIS_0_tready = w_fire;
    assign S_AXIS_1_tready = w_fire;
    assign S_AXIS_2_tready = w_fire;
    assign S_AXIS_3_tready = w_fire;

    fp_agg_credit_counter #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk         (aclk),
        .srst        (srst),
        .i_inc       (w_fire),
        .i_dec       (result_rd_en && !result_empty),
        .o_credit_ok (w_credit_ok)
    );

    always_comb begin
        w_state_next    = r_state;
        w_done_set      = 1'b0;
        w_tlast_err_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (vec_len == '0) w_done_set   = 1'b1;
                    else               w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_fire && w_tlast_bad) begin
                    w_state_next    = ERR;
                    w_tlast_err_set = 1'b1;
                end else if (w_wd_expire) begin
                    w_state_next = ERR;
                end else if (w_fire && w_last_elem) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_result_cnt_next == r_len) begin
                    w_state_next = IDLE;
                    w_done_set   = 1'b1;
                end
            end
            ERR:     w_state_next = ERR;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_issued_cnt <= '0;
            r_result_cnt <= '0;
            r_done       <= 1'b0;
            r_tlast_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_set;
            if (w_tlast_err_set) r_tlast_err <= 1'b1;
            if (w_start_vec) begin
                r_len        <= vec_len;
                r_issued_cnt <= '0;
                r_result_cnt <= '0;
            end else begin
                if (w_fire) r_issued_cnt <= r_issued_cnt + VEC_LEN_WIDTH'(1);
                r_result_cnt <= w_result_cnt_next;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_issue_valid <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) r_issue_data[i] <= '0;
        end else begin
            r_issue_valid <= w_fire;
            if (w_fire) begin
                for (int i = 0; i < NUM_LANES; i++) r_issue_data[i] <= w_tdata[i];
            end
        end
    end

`ifdef FP_AGG_TIMEOUT_EN
    localparam int WDW = credit_width(TIMEOUT_CYCLES);

    logic [WDW-1:0] r_wd_cnt;
    logic           w_partial;
    logic           r_timeout_err;

    // Only a partial arrival counts; an all-valid beat stalled on credits just holds
    assign w_partial   = (|w_tvalid) && !(&w_tvalid);
    assign w_wd_expire = (r_state == RUN) && w_partial &&
                         (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_wd_expire) r_timeout_err <= 1'b1;
            if ((r_state != RUN) || w_fire || !(|w_tvalid)) r_wd_cnt <= '0;
            else if (w_partial)                               r_wd_cnt <= r_wd_cnt + WDW'(1);
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wd_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy          = (r_state == RUN) || (r_state == DRAIN);
    assign done          = r_done;
    assign tlast_err     = r_tlast_err;
    assign issue_tvalid  = r_issue_valid;
    assign issue_tdata_0 = r_issue_data[0];
    assign issue_tdata_1 = r_issue_data[1];
    assign issue_tdata_2 = r_issue_data[2];
    assign issue_tdata_3 = r_issue_data[3];

endmodule

// File: tb/tb_fp_agg_scheduler.sv
// tb_fp_agg_scheduler: table-driven and randomized checks of fp_agg_scheduler against a cycle-level reference.
// Expected timeout behaviour follows FP_AGG_TIMEOUT_EN as the RTL does.
module tb_fp_agg_scheduler;

    localparam int DW       = 32;
    localparam int DEPTH    = 16;
    localparam int VLW      = 16;
    localparam int TMO      = 16;
    localparam int TREE_LAT = 3;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_ERR   = 3;

    logic           aclk = 1'b0;
    logic           srst, start;
    logic [VLW-1:0] vec_len;
    logic [DW-1:0]  tdata [4];
    logic [3:0]     tvalid, tlast, tready;
    logic [DW-1:0]  issueData [4];
    logic           issue_tvalid, tree_result_valid, result_rd_en, result_empty;
    logic           busy, done, tlast_err, timeout_err;

    always #5 aclk = ~aclk;

    fp_agg_scheduler #(
        .FP_DATA_WIDTH (DW),
        .FIFO_DEPTH    (DEPTH),
        .VEC_LEN_WIDTH (VLW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk              (aclk),
        .srst              (srst),
        .start             (start),
        .vec_len           (vec_len),
        .busy              (busy),
        .done              (done),
        .tlast_err         (tlast_err),
        .timeout_err       (timeout_err),
        .S_AXIS_0_tdata    (tdata[0]),
        .S_AXIS_0_tvalid   (tvalid[0]),
        .S_AXIS_0_tlast    (tlast[0]),
        .S_AXIS_0_tready   (tready[0]),
        .S_AXIS_1_tdata    (tdata[1]),
        .S_AXIS_1_tvalid   (tvalid[1]),
        .S_AXIS_1_tlast    (tlast[1]),
        .S_AXIS_1_tready   (tready[1]),
        .S_AXIS_2_tdata    (tdata[2]),
        .S_AXIS_2_tvalid   (tvalid[2]),
        .S_AXIS_2_tlast    (tlast[2]),
        .S_AXIS_2_tready   (tready[2]),
        .S_AXIS_3_tdata    (tdata[3]),
        .S_AXIS_3_tvalid   (tvalid[3]),
        .S_AXIS_3_tlast    (tlast[3]),
        .S_AXIS_3_tready   (tready[3]),
        .issue_tdata_0     (issueData[0]),
        .issue_tdata_1     (issueData[1]),
        .issue_tdata_2     (issueData[2]),
        .issue_tdata_3     (issueData[3]),
        .issue_tvalid      (issue_tvalid),
        .tree_result_valid (tree_result_valid),
        .result_rd_en      (result_rd_en),
        .result_empty      (result_empty)
    );

    // Reference state: the vector in progress, the tree pipe and the result FIFO occupancy
    int         mPhase, mLen, mIssued, mResults, mCredits, mFifo, mWd;
    bit         mTlastErr, mTimeoutErr, mDone;
    bit         pipe [TREE_LAT];
    logic [DW-1:0] mData [4];

    int assertCount = 0;
    int failCount   = 0;
    int dutFires    = 0;
    int dutDones    = 0;

    typedef struct {
        int vecLen;
        int validPct;
        int readPct;
        int expFires;
        int expDones;
    } vec_t;

    vec_t vectors [5];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setLanes(input logic [3:0] v);
        tvalid = v;
        for (int i = 0; i < 4; i++) tdata[i] = $urandom;
        tlast = (mPhase == P_RUN && mIssued == mLen - 1) ? 4'hF : 4'h0;
    endtask

    task automatic modelClear();
        mPhase = P_IDLE; mLen = 0; mIssued = 0; mResults = 0;
        mCredits = 0; mFifo = 0; mWd = 0;
        mTlastErr = 0; mTimeoutErr = 0; mDone = 0;
        for (int i = 0; i < TREE_LAT; i++) pipe[i] = 0;
    endtask

    task automatic doReset();
        srst = 1'b1; start = 1'b0; vec_len = '0; tvalid = '0; tlast = '0;
        result_rd_en = 1'b0; tree_result_valid = 1'b0; result_empty = 1'b1;
        for (int i = 0; i < 4; i++) tdata[i] = '0;
        @(posedge aclk);
        #1;
        srst = 1'b0;
        modelClear();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_issue_tvalid", issue_tvalid, 0);
        checkOutput("rst_tlast_err", tlast_err, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        checkOutput("rst_tready", tready, 0);
        checkOutput("rst_credits", dut.u_credit.r_credits_used, 0);
    endtask

    // One clock cycle: inputs already driven by the caller, model advanced alongside the DUT
    task automatic applyStimulus();
        bit fire, dec, isFinal;
        int prevPhase;
        result_empty      = (mFifo == 0);
        tree_result_valid = pipe[TREE_LAT-1];
        #1;
        fire = (mPhase == P_RUN) && (tvalid == 4'hF) && (mCredits < DEPTH);
        checkOutput("tready", tready, fire ? 4'hF : 4'h0);
        if (fire) for (int i = 0; i < 4; i++) mData[i] = tdata[i];
        @(posedge aclk);
        #1;
        dec       = result_rd_en && (mFifo > 0);
        mCredits += int'(fire) - int'(dec);
        mFifo    += int'(tree_result_valid) - int'(dec);
        mDone     = 0;
        prevPhase = mPhase;
        if (prevPhase == P_IDLE && start) begin
            if (vec_len == 0) mDone = 1;
            else begin
                mPhase = P_RUN; mLen = int'(vec_len); mIssued = 0; mResults = 0;
            end
        end
        if ((prevPhase == P_RUN || prevPhase == P_DRAIN) && tree_result_valid) mResults++;
        if (prevPhase == P_RUN) begin
            if (fire) begin
                isFinal = (mIssued == mLen - 1);
                mIssued++;
                if (tlast != (isFinal ? 4'hF : 4'h0)) begin
                    mTlastErr = 1; mPhase = P_ERR;
                end else if (isFinal) mPhase = P_DRAIN;
            end
`ifdef FP_AGG_TIMEOUT_EN
            if (fire || tvalid == 4'h0) mWd = 0;
            else if (tvalid != 4'hF) begin
                mWd++;
                if (mWd == TMO) begin
                    mTimeoutErr = 1; mPhase = P_ERR;
                end
            end
`endif
        end else mWd = 0;
        if (prevPhase == P_DRAIN && mResults == mLen) begin
            mPhase = P_IDLE; mDone = 1;
        end
        for (int i = TREE_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = fire;
        checkOutput("issue_tvalid", issue_tvalid, fire);
        if (fire) for (int i = 0; i < 4; i++)
            checkOutput($sformatf("issue_tdata_%0d", i), issueData[i], mData[i]);
        checkOutput("done", done, mDone);
        checkOutput("busy", busy, (mPhase == P_RUN || mPhase == P_DRAIN));
        checkOutput("tlast_err", tlast_err, mTlastErr);
        checkOutput("timeout_err", timeout_err, mTimeoutErr);
        if (issue_tvalid) dutFires++;
        if (done) dutDones++;
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (mPhase != P_IDLE && cyc < budget) begin
            setLanes(4'hF);
            result_rd_en = 1'b1;
            applyStimulus();
            cyc++;
        end
        checkOutput({name, "_in_budget"}, (cyc < budget), 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int f0, d0, cyc;
        vectors[0] = '{8,  100, 100, 8,  1};
        vectors[1] = '{1,  70,  50,  1,  1};
        vectors[2] = '{0,  100, 100, 0,  1};
        vectors[3] = '{5,  60,  40,  5,  1};
        vectors[4] = '{24, 80,  30,  24, 1};

        doReset();

        for (int v = 0; v < 5; v++) begin
            f0 = dutFires; d0 = dutDones; cyc = 0;
            vec_len = VLW'(vectors[v].vecLen);
            start   = 1'b1;
            setLanes(4'h0);
            applyStimulus();
            while (mPhase != P_IDLE && cyc < 3000) begin
                logic [3:0] v4;
                for (int i = 0; i < 4; i++) v4[i] = ($urandom_range(99) < vectors[v].validPct);
                setLanes(v4);
                result_rd_en = ($urandom_range(99) < vectors[v].readPct);
                applyStimulus();
                cyc++;
            end
            checkOutput($sformatf("vec%0d_in_budget", v), (cyc < 3000), 1);
            checkOutput($sformatf("vec%0d_fires", v), dutFires - f0, vectors[v].expFires);
            checkOutput($sformatf("vec%0d_dones", v), dutDones - d0, vectors[v].expDones);
        end

        // Back-to-back issue of eight elements
        doReset();
        f0 = dutFires; d0 = dutDones;
        vec_len = 16'd8; start = 1'b1; result_rd_en = 1'b1;
        setLanes(4'hF);
        applyStimulus();
        for (int i = 0; i < 8; i++) begin
            setLanes(4'hF);
            applyStimulus();
        end
        checkOutput("seq1_fires", dutFires - f0, 8);
        waitIdle("seq1", 50);
        checkOutput("seq1_dones", dutDones - d0, 1);

        // Lane 2 arrives late: nothing is accepted until all four are present
        doReset();
        f0 = dutFires;
        vec_len = 16'd2; start = 1'b1;
        setLanes(4'h0);
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            setLanes(4'b1011);
            applyStimulus();
        end
        checkOutput("seq2_no_early_fire", dutFires - f0, 0);
        setLanes(4'hF);
        applyStimulus();
        setLanes(4'h0);
        applyStimulus();
        checkOutput("seq2_one_fire", dutFires - f0, 1);

        // Credit exhaustion with no reads, then a single read frees a single slot
        doReset();
        f0 = dutFires;
        vec_len = 16'd40; start = 1'b1;
        setLanes(4'h0);
        applyStimulus();
        for (int i = 0; i < 25; i++) begin
            setLanes(4'hF);
            applyStimulus();
        end
        checkOutput("seq3_credit_limit", dutFires - f0, 16);
        result_rd_en = 1'b1;
        setLanes(4'hF);
        applyStimulus();
        result_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setLanes(4'hF);
            applyStimulus();
        end
        checkOutput("seq3_one_more", dutFires - f0, 17);

        // Lane 1 raises tlast on the second of four elements
        doReset();
        f0 = dutFires;
        vec_len = 16'd4; start = 1'b1;
        setLanes(4'h0);
        applyStimulus();
        setLanes(4'hF);
        applyStimulus();
        setLanes(4'hF);
        tlast = 4'b0010;
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            setLanes(4'hF);
            vec_len = 16'd2; start = 1'b1;
            applyStimulus();
        end
        checkOutput("seq4_tlast_err", tlast_err, 1);
        checkOutput("seq4_fires", dutFires - f0, 2);
        doReset();
        checkOutput("seq4_err_cleared", tlast_err, 0);

        // Three lanes valid, lane 3 idle
        doReset();
        vec_len = 16'd4; start = 1'b1;
        setLanes(4'h0);
        applyStimulus();
        for (int i = 0; i < 20; i++) begin
            setLanes(4'b0111);
            applyStimulus();
        end
`ifdef FP_AGG_TIMEOUT_EN
        checkOutput("seq5_timeout_err", timeout_err, 1);
`else
        checkOutput("seq5_timeout_err", timeout_err, 0);
`endif

        // Reset in the middle of a vector, then a fresh short vector
        doReset();
        vec_len = 16'd8; start = 1'b1; result_rd_en = 1'b0;
        setLanes(4'h0);
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            setLanes(4'hF);
            applyStimulus();
        end
        checkOutput("seq6_busy_before", busy, 1);
        doReset();
        f0 = dutFires; d0 = dutDones;
        vec_len = 16'd2; start = 1'b1;
        setLanes(4'h0);
        applyStimulus();
        waitIdle("seq6", 50);
        checkOutput("seq6_fires", dutFires - f0, 2);
        checkOutput("seq6_dones", dutDones - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
